// File: rtl/kgp_arb_pkg.sv
// Shared types and widths for the KGP_RISC memory arbiter.
package kgp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int LAT_W  = 4;
    localparam int WAIT_W = 3;

endpackage

// File: rtl/kgp_arb_prio.sv
// Winner select for the arbiter: LS has fixed priority unless IF has lost
// MAX_WAIT conflicts in a row.
module kgp_arb_prio
    import kgp_arb_pkg::*;
#(
    parameter int MAX_WAIT = 2
) (
    input  logic              if_req,
    input  logic              ls_req,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              grant_ls
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    assign grant_ls = ls_req & ~(if_req & (wait_cnt == WAIT_LIMIT));

endmodule

// File: rtl/kgp_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Optional conflict statistics are enabled by defining KGP_ARB_STATS_EN.
module kgp_mem_arbiter
    import kgp_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_valid,
    output logic              if_stall,
    output logic              ls_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t              state;
    logic                owner;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LAT_W-1:0]    lat_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                grant_ls;
    logic                in_access;

    kgp_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .if_req   (if_req),
        .ls_req   (ls_req),
        .wait_cnt (wait_cnt),
        .grant_ls (grant_ls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lat_cnt  <= '0;
            wait_cnt <= '0;
            mem_en   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            mem_en   <= 1'b0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        owner   <= grant_ls ? OWN_LS : OWN_IF;
                        addr_q  <= grant_ls ? ls_addr : if_addr;
                        we_q    <= grant_ls & ls_we;
                        wdata_q <= grant_ls ? ls_wdata : '0;
                        lat_cnt <= LAT_W'(MEM_LAT);
                        mem_en  <= 1'b1;
                        state   <= ACCESS;
                        // An IF win resets the starvation guard; an LS win over a waiting IF advances it.
                        if (!grant_ls) begin
                            wait_cnt <= '0;
                        end else if (if_req && wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_W'(1)) begin
                        if (!we_q) begin
                            if (owner == OWN_LS) ls_rdata <= mem_rdata;
                            else                 if_rdata <= mem_rdata;
                        end
                        if (owner == OWN_LS) ls_valid <= 1'b1;
                        else                 if_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    assign mem_we    = in_access & we_q;
    assign mem_addr  = in_access ? addr_q  : '0;
    assign mem_wdata = in_access ? wdata_q : '0;

    // Stalls are forced low while reset is held so every output reads 0 in reset.
    assign if_stall = if_req & ~if_valid & ~rst;
    assign ls_stall = ls_req & ~ls_valid & ~rst;

`ifdef KGP_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (state == IDLE && if_req && ls_req && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule
